// File: rtl/instr_decode_reg.sv
// Registered RV64I decode stage: splits the instruction into its fields and classifies
// the immediate format. A two-slot skid buffer keeps full throughput with every output registered.
module instr_decode_reg #(
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   i_flush,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [PC_WIDTH-1:0]    i_pc,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic [6:0]             o_opcode,
  output logic [4:0]             o_rd,
  output logic [2:0]             o_funct3,
  output logic [4:0]             o_rs1,
  output logic [4:0]             o_rs2,
  output logic [6:0]             o_funct7,
  output logic [24:0]            o_imm,
  output logic [2:0]             o_imm_type,
  output logic                   o_illegal
);

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic [2:0]             imm_type;
    logic                   illegal;
  } slot_t;

  slot_t out_q, out_d, skid_q, skid_d, in_e;
  logic  out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic  accept, drain;
  logic [2:0] dec_type;
  logic       dec_ill;

  // R-type and fence carry no immediate but are legal; they share the I select.
  always_comb begin
    dec_type = IMM_I;
    dec_ill  = 1'b0;
    case (i_instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011,
      7'b1100111, 7'b1110011:             dec_type = IMM_I;
      7'b0100011:                         dec_type = IMM_S;
      7'b1100011:                         dec_type = IMM_B;
      7'b1101111:                         dec_type = IMM_J;
      7'b0110111, 7'b0010111:             dec_type = IMM_U;
      7'b0110011, 7'b0111011, 7'b0001111: dec_type = IMM_I;
      default:                            dec_ill  = 1'b1;
    endcase
  end

  always_comb begin
    in_e.pc       = i_pc;
    in_e.instr    = i_instr;
    in_e.imm_type = dec_type;
    in_e.illegal  = dec_ill;
  end

  assign accept = i_valid & ~skid_v_q;
  assign drain  = out_v_q & i_ready;

  always_comb begin
    out_d    = out_q;
    skid_d   = skid_q;
    out_v_d  = out_v_q;
    skid_v_d = skid_v_q;
    if (i_flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (!out_v_q || drain) begin
      if (skid_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = accept;
        if (accept) skid_d = in_e;
      end else begin
        out_v_d = accept;
        if (accept) out_d = in_e;
      end
    end else if (accept) begin
      skid_d   = in_e;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      out_q    <= '0;
      skid_q   <= '0;
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      skid_q   <= skid_d;
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  // Ready depends only on the skid register, never on i_ready.
  assign o_ready    = ~skid_v_q;
  assign o_valid    = out_v_q;
  assign o_pc       = out_q.pc;
  assign o_opcode   = out_q.instr[6:0];
  assign o_rd       = out_q.instr[11:7];
  assign o_funct3   = out_q.instr[14:12];
  assign o_rs1      = out_q.instr[19:15];
  assign o_rs2      = out_q.instr[24:20];
  assign o_funct7   = out_q.instr[31:25];
  assign o_imm      = out_q.instr[31:7];
  assign o_imm_type = out_q.imm_type;
  assign o_illegal  = out_q.illegal;

endmodule
